// File: rtl/asteroids_pkg.sv
// Shared types and constants for the asteroid draw scheduler.
package asteroids_pkg;

    localparam int COORD_W       = 10;
    localparam int SPRITE_SEL_W  = 3;
    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_TIMEOUT   = 2048;

    // Scheduler walk states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CHECK = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } sched_state_e;

    // Position and sprite handed to the draw unit
    typedef struct packed {
        logic [COORD_W-1:0]      x;
        logic [COORD_W-1:0]      y;
        logic [SPRITE_SEL_W-1:0] spr;
    } sprite_req_t;

endpackage

// File: rtl/draw_watchdog.sv
// Per-sprite watchdog: counts cycles spent waiting on the draw unit and
// flags when the wait has lasted TIMEOUT cycles.
module draw_watchdog #(
    parameter int TIMEOUT = 2048,
    parameter int TO_W    = 12
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TO_W-1:0] count;

    // Cycle counter: cleared before each draw, advances while waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    // count == TIMEOUT-1 means this is the TIMEOUT-th waiting cycle
    assign expire = (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/asteroid_draw_scheduler.sv
// Walks the asteroid slot table once per frame tick, issuing one plot per
// active slot and waiting for the draw unit (or the watchdog) before moving on.
module asteroid_draw_scheduler
    import asteroids_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int IDX_W     = 3,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int TO_W      = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic [IDX_W-1:0]        slot_idx,
    input  logic                    slot_active,
    input  logic [COORD_W-1:0]      slot_x,
    input  logic [COORD_W-1:0]      slot_y,
    input  logic [SPRITE_SEL_W-1:0] slot_sprite,
    output logic [COORD_W-1:0]      x_pos,
    output logic [COORD_W-1:0]      y_pos,
    output logic [SPRITE_SEL_W-1:0] sprite_sel,
    output logic                    plot,
    input  logic                    draw_done,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    timeout_err
);

    sched_state_e     state, state_nxt;
    logic             last_slot;
    logic             wd_expire;

    sprite_req_t      req_q, req_d;
    logic [IDX_W-1:0] idx_d;
    logic             busy_d, plot_d, frame_done_d, terr_d;

    assign last_slot = (slot_idx == IDX_W'(NUM_SLOTS - 1));

    draw_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == ISSUE),
        .enable  (state == WAIT),
        .expire  (wd_expire)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: draw_done only matters in WAIT, and wins over a same-cycle expiry
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = CHECK;
            CHECK:   state_nxt = slot_active ? ISSUE : NEXT;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (draw_done || wd_expire) state_nxt = NEXT;
            NEXT:    state_nxt = last_slot ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output next-values; status flags are decoded from the next state so the
    // registered outputs line up with the state they describe
    always_comb begin
        busy_d       = (state_nxt != IDLE);
        plot_d       = (state_nxt == ISSUE);
        frame_done_d = (state_nxt == DONE);
        idx_d        = slot_idx;
        req_d        = req_q;
        terr_d       = timeout_err;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    terr_d = 1'b0;
                end
            end
            CHECK: begin
                if (slot_active)
                    req_d = '{x: slot_x, y: slot_y, spr: slot_sprite};
            end
            WAIT: begin
                if (wd_expire && !draw_done)
                    terr_d = 1'b1;
            end
            NEXT: begin
                if (!last_slot)
                    idx_d = slot_idx + 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_idx    <= '0;
            req_q       <= '0;
            busy        <= 1'b0;
            plot        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            slot_idx    <= idx_d;
            req_q       <= req_d;
            busy        <= busy_d;
            plot        <= plot_d;
            frame_done  <= frame_done_d;
            timeout_err <= terr_d;
        end
    end

    assign x_pos      = req_q.x;
    assign y_pos      = req_q.y;
    assign sprite_sel = req_q.spr;

endmodule

// File: tb/tb_asteroid_draw_scheduler.sv
// Self-checking bench: directed and random frames against a frame-level model
// that predicts plot cycles, slot order, busy/frame_done timing and errors.
module tb_asteroid_draw_scheduler;

    localparam int NS   = 4;
    localparam int IW   = 2;
    localparam int TO   = 16;
    localparam int TW   = 5;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [IW-1:0] slot_idx;
    logic          slot_active;
    logic [9:0]    slot_x, slot_y, x_pos, y_pos;
    logic [2:0]    slot_sprite, sprite_sel;
    logic          plot, draw_done, busy, frame_done, timeout_err;

    int vec  = 0;
    int miss = 0;

    // Slot table contents and draw-unit behaviour per slot
    logic       tbl_act [NS];
    logic [9:0] tbl_x   [NS];
    logic [9:0] tbl_y   [NS];
    logic [2:0] tbl_spr [NS];
    int         dly     [NS];   // WAIT cycle of draw_done; 0 or >TO = never
    bit         hold_issue;
    int         restart_cyc;
    int         abort_cyc;

    // Model state carried between frames
    logic [9:0] cur_x, cur_y;
    logic [2:0] cur_spr;
    bit         prev_err;
    int         rem;

    bit e_plot [MAXC];
    int e_idx  [MAXC];

    asteroid_draw_scheduler #(
        .NUM_SLOTS (NS),
        .IDX_W     (IW),
        .TIMEOUT   (TO),
        .TO_W      (TW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .slot_idx    (slot_idx),
        .slot_active (slot_active),
        .slot_x      (slot_x),
        .slot_y      (slot_y),
        .slot_sprite (slot_sprite),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .sprite_sel  (sprite_sel),
        .plot        (plot),
        .draw_done   (draw_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Synchronous table RAM: data follows slot_idx by one cycle
    always @(posedge clk) begin
        slot_active <= tbl_act[slot_idx];
        slot_x      <= tbl_x[slot_idx];
        slot_y      <= tbl_y[slot_idx];
        slot_sprite <= tbl_spr[slot_idx];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " slot_idx"},    32'(slot_idx),    0);
        chk({tag, " x_pos"},       32'(x_pos),       0);
        chk({tag, " y_pos"},       32'(y_pos),       0);
        chk({tag, " sprite_sel"},  32'(sprite_sel),  0);
        chk({tag, " plot"},        32'(plot),        0);
        chk({tag, " busy"},        32'(busy),        0);
        chk({tag, " frame_done"},  32'(frame_done),  0);
        chk({tag, " timeout_err"}, 32'(timeout_err), 0);
    endtask

    // Predict the frame from the table, then start it and compare every cycle
    task automatic run_frame(input string name);
        int  t, w, first_err;
        bit  exp_terr;
        t = 0;
        first_err = -1;
        for (int c = 0; c < MAXC; c++) begin
            e_plot[c] = 1'b0;
            e_idx[c]  = -1;
        end
        for (int s = 0; s < NS; s++) begin
            e_idx[t+1] = s;
            if (tbl_act[s]) begin
                e_plot[t+3] = 1'b1;
                e_idx[t+3]  = s;
                if (dly[s] >= 1 && dly[s] <= TO) begin
                    w = dly[s];
                end else begin
                    w = TO;
                    if (first_err < 0) first_err = t + 3 + TO + 1;
                end
                t += 4 + w;
            end else begin
                t += 3;
            end
        end
        rem = 0;
        @(negedge clk);
        for (int c = 0; c <= t + 3; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == 0) || (c == restart_cyc);
            // Draw unit: pulse draw_done in the requested WAIT cycle
            if (rem > 0) begin
                rem--;
                draw_done = (rem == 0);
            end else begin
                draw_done = 1'b0;
            end
            if (plot === 1'b1) begin
                rem = (dly[slot_idx] >= 1 && dly[slot_idx] <= TO) ? dly[slot_idx] : 0;
                draw_done = hold_issue;
            end
            if (e_plot[c]) begin
                cur_x   = tbl_x[e_idx[c]];
                cur_y   = tbl_y[e_idx[c]];
                cur_spr = tbl_spr[e_idx[c]];
            end
            exp_terr = (c == 0) ? prev_err : (first_err >= 0 && c >= first_err);
            chk($sformatf("%s c%0d plot", name, c),        32'(plot),        32'(e_plot[c]));
            chk($sformatf("%s c%0d busy", name, c),        32'(busy),        32'(c >= 1 && c <= t + 1));
            chk($sformatf("%s c%0d frame_done", name, c),  32'(frame_done),  32'(c == t + 1));
            chk($sformatf("%s c%0d timeout_err", name, c), 32'(timeout_err), 32'(exp_terr));
            chk($sformatf("%s c%0d x_pos", name, c),       32'(x_pos),       32'(cur_x));
            chk($sformatf("%s c%0d y_pos", name, c),       32'(y_pos),       32'(cur_y));
            chk($sformatf("%s c%0d sprite_sel", name, c),  32'(sprite_sel),  32'(cur_spr));
            if (e_idx[c] >= 0)
                chk($sformatf("%s c%0d slot_idx", name, c), 32'(slot_idx), 32'(e_idx[c]));
            if (c == abort_cyc) begin
                #2 reset_n = 1'b0;
                #1 chk_all_zero({name, " async reset"});
                start     = 1'b0;
                draw_done = 1'b0;
                rem       = 0;
                cur_x     = '0;
                cur_y     = '0;
                cur_spr   = '0;
                prev_err  = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
        end
        start     = 1'b0;
        draw_done = 1'b0;
        prev_err  = (first_err >= 0);
    endtask

    task automatic clear_table();
        for (int s = 0; s < NS; s++) begin
            tbl_act[s] = 1'b0;
            tbl_x[s]   = 10'($urandom_range(0, 1023));
            tbl_y[s]   = 10'($urandom_range(0, 1023));
            tbl_spr[s] = 3'($urandom_range(0, 7));
            dly[s]     = 1;
        end
        hold_issue  = 1'b0;
        restart_cyc = 0;
        abort_cyc   = -1;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        draw_done = 1'b0;
        cur_x     = '0;
        cur_y     = '0;
        cur_spr   = '0;
        prev_err  = 1'b0;
        clear_table();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // All slots inactive: 12 walk cycles, frame_done in cycle 13
        clear_table();
        run_frame("all_inactive");

        // Two active slots answered 5 cycles after each plot
        clear_table();
        tbl_act[1] = 1'b1; tbl_x[1] = 10'd100; tbl_y[1] = 10'd50;  tbl_spr[1] = 3'd2; dly[1] = 5;
        tbl_act[3] = 1'b1; tbl_x[3] = 10'd600; tbl_y[3] = 10'd400; tbl_spr[3] = 3'd5; dly[3] = 5;
        run_frame("two_active");

        // Hung draw on slot 0: watchdog aborts, walk still completes
        clear_table();
        tbl_act[0] = 1'b1; dly[0] = 0;
        run_frame("timeout");

        // Next start clears the sticky error
        clear_table();
        run_frame("err_clear");

        // Completion on the last permissible WAIT cycle is not an error
        clear_table();
        tbl_act[2] = 1'b1; dly[2] = TO;
        run_frame("done_at_limit");

        // draw_done during ISSUE is ignored; WAIT cycle 3 pulse advances
        clear_table();
        tbl_act[0] = 1'b1; dly[0] = 3; hold_issue = 1'b1;
        run_frame("issue_done_ignored");

        // Start re-pulsed mid-frame and during DONE
        clear_table();
        tbl_act[2] = 1'b1; dly[2] = 4;
        restart_cyc = 6;
        run_frame("restart_busy");
        clear_table();
        restart_cyc = 13;
        run_frame("restart_done");

        // Reset while waiting on slot 1 with timeout_err already set
        clear_table();
        tbl_act[0] = 1'b1; dly[0] = 0;
        tbl_act[1] = 1'b1; dly[1] = 0;
        abort_cyc = 30;
        run_frame("abort");
        clear_table();
        tbl_act[0] = 1'b1; dly[0] = 2;
        run_frame("after_reset");

        // Random tables, delays (some never answered) and restarts
        for (int f = 0; f < 24; f++) begin
            clear_table();
            for (int s = 0; s < NS; s++) begin
                tbl_act[s] = 1'($urandom_range(0, 1));
                dly[s]     = $urandom_range(1, TO + 3);
            end
            hold_issue  = 1'($urandom_range(0, 1));
            restart_cyc = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 12) : 0;
            run_frame($sformatf("rand%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
